// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-cycle CPU front end.
//   fetch_state_t : RUN / HALT / FAULT encodings driven on pc_fetch_unit.state
//   PC_W          : program-counter width (byte addressed)
//   INSTR_W       : instruction word width
//   PC_INC        : byte distance between consecutive instructions
//   sat_inc16     : 16-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam logic [PC_W-1:0] PC_INC = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_t;

    // Counter increment that saturates instead of wrapping, so a long
    // debug run never makes the retired count look small again.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational candidate-PC generator for the fetch stage.
//   pc              in  16  current (registered) program counter
//   branch_offset   in  8   signed word offset of a taken branch
//   jump_target     in  16  absolute byte address of a jump
//   seq_pc          out 16  pc + 2
//   branch_pc       out 16  pc + 2 + (sext(branch_offset) << 1)
//   jump_pc         out 16  jump_target passed through
//   pc_out_of_range out 1   pc is at or beyond the end of instruction memory
//   pc_misaligned   out 1   pc is odd
//   jump_misaligned out 1   jump_target is odd
// All arithmetic wraps modulo 2^16; a wrapped result is caught by the
// range flag on the following cycle rather than here.
// ---------------------------------------------------------------------------
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      branch_offset,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] branch_pc,
    output logic [PC_W-1:0] jump_pc,
    output logic            pc_out_of_range,
    output logic            pc_misaligned,
    output logic            jump_misaligned
);

    logic [PC_W-1:0] offset_bytes;

    // Branch offsets count instructions, so sign-extend and scale by two
    // to get a byte displacement relative to the sequential PC.
    assign offset_bytes = {{7{branch_offset[7]}}, branch_offset, 1'b0};

    assign seq_pc    = pc + PC_INC;
    assign branch_pc = seq_pc + offset_bytes;
    assign jump_pc   = jump_target;

    // Widened compare so an instruction memory of exactly 64 KiB still
    // treats every 16-bit address as in range.
    assign pc_out_of_range = ({1'b0, pc} >= 17'(IMEM_BYTES));
    assign pc_misaligned   = pc[0];
    assign jump_misaligned = jump_target[0];

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program counter, next-PC selection, run/halt/fault state machine and
// retired-instruction counter for the single-cycle CPU.
//   clk            in  1   system clock, rising edge
//   rst_n          in  1   asynchronous active-low reset
//   stall          in  1   hold PC, no retire
//   branch_taken   in  1   PC-relative branch
//   branch_offset  in  8   signed word offset
//   jump           in  1   absolute jump (wins over branch)
//   jump_target    in  16  absolute byte address
//   halt_req       in  1   retire current instruction, then HALT
//   instr_in       in  16  instruction memory read data for pc
//   pc             out 16  instruction memory address
//   instr          out 16  instr_in forwarded to the decoder
//   instr_valid    out 1   instr usable: RUN and pc legal
//   state          out 2   00 RUN, 01 HALT, 10 FAULT
//   retired        out 16  saturating retired-instruction count
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter int unsigned     IMEM_BYTES = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [7:0]          branch_offset,
    input  logic                jump,
    input  logic [PC_W-1:0]     jump_target,
    input  logic                halt_req,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [PC_W-1:0]     pc,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [1:0]          state,
    output logic [15:0]         retired
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     retired_q, retired_d;
    logic            retire;

    logic [PC_W-1:0] seq_pc, branch_pc, jump_pc;
    logic            pc_out_of_range, pc_misaligned, jump_misaligned;
    logic            pc_bad;

    next_pc_calc #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next_pc_calc (
        .pc              (pc_q),
        .branch_offset   (branch_offset),
        .jump_target     (jump_target),
        .seq_pc          (seq_pc),
        .branch_pc       (branch_pc),
        .jump_pc         (jump_pc),
        .pc_out_of_range (pc_out_of_range),
        .pc_misaligned   (pc_misaligned),
        .jump_misaligned (jump_misaligned)
    );

    assign pc_bad = pc_out_of_range | pc_misaligned;

    // Next-state, next-PC and retire decision. Only RUN looks at the
    // controls; the checks are ordered so that an illegal fetch address
    // beats everything, then stall, halt, jump, branch and plain
    // sequential flow. HALT and FAULT simply hold until reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        retire  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (pc_bad) begin
                    state_d = ST_FAULT;
                end else if (stall) begin
                    // hold everything this cycle
                end else if (halt_req) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else if (jump) begin
                    retire = 1'b1;
                    if (jump_misaligned) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = jump_pc;
                    end
                end else if (branch_taken) begin
                    retire = 1'b1;
                    pc_d   = branch_pc;
                end else begin
                    retire = 1'b1;
                    pc_d   = seq_pc;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                // Unused encoding: park in FAULT so it is visible on debug.
                state_d = ST_FAULT;
            end
        endcase
    end

    // Retired counter only advances on a retiring cycle and never wraps.
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = sat_inc16(retired_q);
        end
    end

    // State, PC and counter registers. Reset is asynchronous so the fetch
    // address snaps back to RESET_PC the moment rst_n falls, whatever the
    // machine was doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_in;
    assign instr_valid = (state_q == ST_RUN) && !pc_bad;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Scoreboard bench for pc_fetch_unit (RESET_PC=0, IMEM_BYTES=32). A
// reference model predicts pc/state/retired/instr_valid for each driven
// cycle; predictions are queued and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    typedef enum logic [1:0] {
        M_RUN   = 2'b00,
        M_HALT  = 2'b01,
        M_FAULT = 2'b10
    } model_state_t;

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  st;
        logic [15:0] ret;
        logic        valid;
    } expect_t;

    localparam int MEM_BYTES = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_offset = 8'h00;
    logic        jump = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        halt_req = 1'b0;
    logic [15:0] instr_in = 16'h0000;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [1:0]  state;
    logic [15:0] retired;

    int vectors_applied = 0;
    int miscompares = 0;

    expect_t      sb[$];
    logic [15:0]  m_pc;
    model_state_t m_state;
    logic [15:0]  m_retired;

    pc_fetch_unit #(
        .RESET_PC   (16'h0000),
        .IMEM_BYTES (MEM_BYTES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .instr_in      (instr_in),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .state         (state),
        .retired       (retired)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if something wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic model_valid(input model_state_t s, input logic [15:0] p);
        return (s == M_RUN) && (p < 16'(MEM_BYTES)) && !p[0];
    endfunction

    // Asynchronous reset pulse away from any clock edge; the outputs must
    // change without waiting for a clock.
    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pc", pc, 16'h0000);
        checkOutput("rst_state", {14'd0, state}, 16'd0);
        checkOutput("rst_retired", retired, 16'd0);
        checkOutput("rst_valid", {15'd0, instr_valid}, 16'd1);
        m_pc      = 16'h0000;
        m_state   = M_RUN;
        m_retired = 16'd0;
        sb.delete();
        #1;
        rst_n = 1'b1;
    endtask

    // Drive one cycle of controls, predict its effect, push the
    // prediction, then compare it against the DUT after the edge.
    task automatic applyStimulus(input logic s, input logic br, input logic [7:0] off,
                                 input logic jmp, input logic [15:0] tgt, input logic hlt);
        expect_t      e;
        expect_t      got;
        logic [15:0]  n_pc;
        model_state_t n_state;
        logic         do_retire;
        logic [15:0]  word;

        word          = 16'($urandom);
        stall         = s;
        branch_taken  = br;
        branch_offset = off;
        jump          = jmp;
        jump_target   = tgt;
        halt_req      = hlt;
        instr_in      = word;

        n_pc      = m_pc;
        n_state   = m_state;
        do_retire = 1'b0;
        if (m_state == M_RUN) begin
            if (!model_valid(m_state, m_pc)) begin
                n_state = M_FAULT;
            end else if (s) begin
                n_state = M_RUN;
            end else if (hlt) begin
                do_retire = 1'b1;
                n_state   = M_HALT;
            end else if (jmp) begin
                do_retire = 1'b1;
                if (tgt[0]) n_state = M_FAULT;
                else        n_pc    = tgt;
            end else if (br) begin
                do_retire = 1'b1;
                n_pc = 16'(int'(m_pc) + 2 + 2 * int'($signed(off)));
            end else begin
                do_retire = 1'b1;
                n_pc = 16'(int'(m_pc) + 2);
            end
        end
        if (do_retire && m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
        m_pc    = n_pc;
        m_state = n_state;

        e.pc    = m_pc;
        e.st    = m_state;
        e.ret   = m_retired;
        e.valid = model_valid(m_state, m_pc);
        sb.push_back(e);

        #1;
        checkOutput("instr_pass", instr, word);

        @(posedge clk);
        #1;
        checkOutput("sb_depth", 16'(sb.size()), 16'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            checkOutput("pc", pc, got.pc);
            checkOutput("state", {14'd0, state}, {14'd0, got.st});
            checkOutput("retired", retired, got.ret);
            checkOutput("valid", {15'd0, instr_valid}, {15'd0, got.valid});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        $display("[TB] pc_fetch_unit bench starting");
        m_pc = 16'h0000;
        m_state = M_RUN;
        m_retired = 16'd0;

        // Reset and five sequential fetches.
        doReset();
        idleCycles(5);
        checkOutput("seq5_pc", pc, 16'd10);
        checkOutput("seq5_retired", retired, 16'd5);
        checkOutput("seq5_state", {14'd0, state}, 16'd0);

        // Backward branch from 4, then forward branch from 2.
        doReset();
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 8'hFE, 1'b0, 16'h0000, 1'b0);
        checkOutput("br_back_pc", pc, 16'd2);
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0, 16'h0000, 1'b0);
        checkOutput("br_fwd_pc", pc, 16'd10);

        // Jump beats branch; then a misaligned jump faults and sticks.
        doReset();
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 8'h01, 1'b1, 16'h001C, 1'b0);
        checkOutput("jmp_win_pc", pc, 16'd28);
        doReset();
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0005, 1'b0);
        checkOutput("jmp_odd_state", {14'd0, state}, 16'd2);
        checkOutput("jmp_odd_pc", pc, 16'd6);
        checkOutput("jmp_odd_valid", {15'd0, instr_valid}, 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0008, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h02, 1'b0, 16'h0000, 1'b0);

        // Run off the end of instruction memory.
        doReset();
        idleCycles(15);
        checkOutput("end_pc30", pc, 16'd30);
        idleCycles(1);
        checkOutput("end_pc32", pc, 16'd32);
        checkOutput("end_valid", {15'd0, instr_valid}, 16'd0);
        checkOutput("end_retired", retired, 16'd16);
        idleCycles(1);
        checkOutput("end_state", {14'd0, state}, 16'd2);
        idleCycles(10);
        checkOutput("end_hold_pc", pc, 16'd32);
        checkOutput("end_hold_retired", retired, 16'd16);

        // Stall, then halt, then ignored jumps.
        doReset();
        idleCycles(4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        checkOutput("stall_pc", pc, 16'd8);
        checkOutput("stall_retired", retired, 16'd4);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkOutput("halt_state", {14'd0, state}, 16'd1);
        checkOutput("halt_retired", retired, 16'd5);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0010, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h02, 1'b0, 16'h0000, 1'b0);
        checkOutput("halt_hold_pc", pc, 16'd8);

        // Halt at pc 12, then reset mid-cycle.
        doReset();
        idleCycles(6);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkOutput("halt12_pc", pc, 16'd12);
        checkOutput("halt12_state", {14'd0, state}, 16'd1);
        doReset();

        // Randomised traffic against the model.
        for (int i = 0; i < 80; i++) begin
            logic [15:0] t;
            int off;
            if (m_state != M_RUN) doReset();
            t   = 16'($urandom_range(0, 17)) << 1;
            if ($urandom_range(0, 9) == 0) t = t | 16'd1;
            off = $urandom_range(0, 8) - 4;
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 8'(off),
                          $urandom_range(0, 7) == 0, t, $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
